// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched at start; the result is committed on the last busy edge.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_e      state;
    md_op_e      op_in;
    md_op_e      op_q;
    logic [3:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    assign op_in  = md_op_e'(MDOp);
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Result of the latched op, consumed only on the final busy edge.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        res_we = 1'b1;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(a_q) / $signed(b_q);
                    res_hi = $signed(a_q) % $signed(b_q);
                end
            end
            OP_DIVU: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            op_q  <= OP_NONE;
            cnt   <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Hi    <= 32'd0;
            Lo    <= 32'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (op_in)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                a_q   <= A;
                                b_q   <= B;
                                op_q  <= op_in;
                                cnt   <= (op_in == OP_MULT || op_in == OP_MULTU) ? MULT_CNT : DIV_CNT;
                                state <= RUN;
                                Busy  <= 1'b1;
                            end
                            OP_MTHI: Hi <= A;
                            OP_MTLO: Lo <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Start is deliberately ignored here; the controller stalls instead.
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        if (res_we) begin
                            Hi <= res_hi;
                            Lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit on the execute side of the datapath, holding the architectural HI/LO registers.
- Consumes the GRF read data (rs on A, rt on B) and a decoded op from the controller.
- Produces HI/LO for the write-back mux (mfhi/mflo), plus a Busy flag the controller uses to stall further md/mfhi/mflo instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  op request, sampled at rising edge
- MDOp  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved
- A  input  32  rs operand
- B  input  32  rt operand
- Busy  output  1  multi-cycle op in progress
- Done  output  1  one-cycle pulse, HI/LO just updated by a mult/div
- Hi  output  32  HI register
- Lo  output  32  LO register

Behaviour:
- Reset (Reset=0, async, any time including mid-op):
  - Hi=0, Lo=0, Busy=0, Done=0.
  - Counter and operand latches cleared.
  - In-flight op is discarded.
- States:
  - IDLE -> RUN on Start=1 with MDOp in 001..100 while IDLE.
  - RUN -> IDLE when the counter reaches its final cycle.
- Mult/div timing (Start high in cycle 0):
  - Edge ending cycle 0: A, B and op are latched; counter loads N (MULT_CYCLES or DIV_CYCLES).
  - Busy=1 in cycles 1..N.
  - Edge ending cycle N: Hi/Lo are written.
  - Cycle N+1: Busy=0, Done=1 for exactly one cycle.
  - Hi/Lo keep their old values throughout cycles 1..N.
- Results use the operands latched at start; later changes to A/B have no effect.
- MULT: signed 32x32 -> 64-bit product; Hi = product[63:32], Lo = product[31:0].
- MULTU: as MULT, unsigned.
- DIV:
  - Lo = signed quotient, truncated toward zero.
  - Hi = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- DIVU: Lo = unsigned quotient, Hi = unsigned remainder.
- Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES busy period still runs; Hi/Lo unchanged at the end; Done still pulses.
- MTHI/MTLO while IDLE with Start=1:
  - Hi (or Lo) = A at the same edge.
  - No Busy, no Done.
  - Value is visible the next cycle.
- Start=1 while Busy=1: ignored entirely, for any MDOp; the controller is responsible for stalling.
- Start=1 with MDOp 000 or 111: no effect.
- Back-to-back: Start may be asserted in cycle N+1 (Busy=0); it is accepted normally while Done=1.
- Hi/Lo are directly register-driven, with no combinational path from inputs.
- Internal arithmetic may be combinational at the final edge or iterative; the external timing above is mandatory.

Test Plan:
- Reset: assert Reset=0 for 2 cycles, release -> Hi=0, Lo=0, Busy=0, Done=0.
- MULT: A=0xFFFFFFFE (-2), B=3, Start 1 cycle -> Busy=1 for exactly 5 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, Done pulses once. MULTU with the same operands -> Hi=0x00000002, Lo=0xFFFFFFFA.
- DIV: A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=2 -> Lo=3, Hi=1.
- Divide by zero:
  - Preload with MTHI A=0x1234 and MTLO A=0x5678, then DIV B=0.
  - Required: Busy for 10 cycles, Done pulses, Hi=0x1234, Lo=0x5678.
  - Also check overflow: 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start during Busy: start MULT 4x5, and in busy cycle 2 pulse Start with MTLO A=0xDEAD.
  - Required: Lo=20 and Hi=0 at the end; 0xDEAD is never written.
  - Also change A/B mid-op -> result unchanged.
- Reset mid-op: start DIV, drop Reset=0 in busy cycle 4 (between edges) -> Busy falls immediately, Hi=Lo=0, no Done after release.
- Back-to-back: issue MULTU 2x3 in the Done cycle of a prior op -> accepted, correct result after 5 further busy cycles.
